switch_debounce3: RTL

SWITCH_DEBOUNCE3 -- requirements
Module: switch_debounce3

---
 rtl/switch_debounce3.sv | 131 +++++++++++++
 1 files changed

// File: rtl/switch_debounce3.sv
// Three-channel switch debouncer with rise/fall/any-change pulses.
// Each channel: 2-flop synchronizer, stability counter, registered edge pulses.
module switch_debounce3 #(
    parameter int unsigned DB_CYCLES = 16,
    parameter int unsigned CNT_W     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] sw_raw,
    output logic [2:0] sw_db,
    output logic [2:0] sw_rise,
    output logic [2:0] sw_fall,
    output logic       any_change
);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [2:0]       s1_q;
    logic [2:0]       s2_q;
    logic [2:0]       stable_q;
    logic [2:0]       stable_d;
    logic [2:0]       prev_q;
    logic [2:0]       rise_q;
    logic [2:0]       rise_d;
    logic [2:0]       fall_q;
    logic [2:0]       fall_d;
    logic             any_q;
    logic             any_d;
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];
    state_e           state_q [3];
    state_e           state_d [3];

    // Two-flop synchronizer on the raw switch levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 3'b000;
            s2_q <= 3'b000;
        end else begin
            s1_q <= sw_raw;
            s2_q <= s1_q;
        end
    end

    // Per-channel state, counter and accepted level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i]   <= '0;
                state_q[i] <= IDLE;
            end
        end else begin
            stable_q <= stable_d;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i]   <= cnt_d[i];
                state_q[i] <= state_d[i];
            end
        end
    end

    // Next state: count consecutive mismatches, accept after DB_CYCLES.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i]   = cnt_q[i];
            state_d[i] = state_q[i];
            unique case (state_q[i])
                IDLE: begin
                    if (s2_q[i] != stable_q[i]) begin
                        cnt_d[i]   = CNT_ONE;
                        state_d[i] = COUNT;
                    end else begin
                        cnt_d[i] = '0;
                    end
                end
                COUNT: begin
                    if (s2_q[i] == stable_q[i]) begin
                        cnt_d[i]   = '0;
                        state_d[i] = IDLE;
                    end else if (cnt_q[i] == CNT_MAX) begin
                        stable_d[i] = s2_q[i];
                        cnt_d[i]    = '0;
                        state_d[i]  = IDLE;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                default: begin
                    cnt_d[i]   = '0;
                    state_d[i] = IDLE;
                end
            endcase
        end
    end

    // Pulses fire one cycle after sw_db changes, so compare against
    // a delayed copy of the accepted level.
    always_comb begin
        rise_d = stable_q & ~prev_q;
        fall_d = ~stable_q & prev_q;
        any_d  = |(rise_d | fall_d);
    end

    // Registered edge pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 3'b000;
            rise_q <= 3'b000;
            fall_q <= 3'b000;
            any_q  <= 1'b0;
        end else begin
            prev_q <= stable_q;
            rise_q <= rise_d;
            fall_q <= fall_d;
            any_q  <= any_d;
        end
    end

    assign sw_db      = stable_q;
    assign sw_rise    = rise_q;
    assign sw_fall    = fall_q;
    assign any_change = any_q;

endmodule
